rsa_cmd_ctrl: RTL
=================

RSA_CMD_CTRL -- requirements
Module: rsa_cmd_ctrl

Interface
REQ-001 SHALL have parameter TX_SIZE, 1024, ARM<->FPGA data bus width.
REQ-002 SHALL have parameter OP_WIDTH, 512, operand and result width; TX_SIZE == 2*OP_WIDTH is required.
REQ-003 SHALL have parameter TIMEOUT_CYC, 2**20, core watchdog limit in cycles.
REQ-004 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high.
REQ-006 SHALL have arm_to_fpga_cmd  input  32  command; bits [2:0] opcode, rest ignored.
REQ-007 SHALL have arm_to_fpga_cmd_valid  input  1  command strobe.
REQ-008 SHALL have fpga_to_arm_done / fpga_to_arm_done_read  output/input  1  completion handshake.
REQ-009 SHALL have arm_to_fpga_data_valid / arm_to_fpga_data_ready  input/output  1  inbound data handshake.
REQ-010 SHALL have arm_to_fpga_data  input  TX_SIZE  inbound operand pair.
REQ-011 SHALL have fpga_to_arm_data_valid / fpga_to_arm_data_ready  output/input  1  outbound data handshake.
REQ-012 SHALL have fpga_to_arm_data  output  TX_SIZE  result, zero-extended.
REQ-013 SHALL have core_start  output  1  one-cycle start pulse to exponentiation core.
REQ-014 SHALL have core_mode  output  1  0 = exponentiation, 1 = single Montgomery multiply.
REQ-015 SHALL have core_modulus, core_rmodm, core_rsqmodm, core_exponent, core_x  output  OP_WIDTH each  registered operands.
REQ-016 SHALL have core_done  input  1, core_result  input  OP_WIDTH  core completion and result.
REQ-017 SHALL have status  output  4  {err_code[1:0], result_valid, busy}.

Function
REQ-018 Opcodes SHALL be: 0 LOAD_MOD (low half -> modulus, high -> rmodm), 1 LOAD_RSQ (low -> rsqmodm, high -> x), 2 LOAD_EXP (low -> exponent), 3 COMPUTE_EXP, 4 COMPUTE_MONT, 5 READ_RESULT, 6 CLEAR, 7 illegal.
REQ-019 FSM states SHALL be IDLE, LOAD, START, COMPUTE, WRITE, DONE; cmd_valid SHALL be sampled only in IDLE and ignored elsewhere.
REQ-020 IDLE: opcodes 0-2 -> LOAD; 3/4 -> START with core_mode latched; 5 -> WRITE; 6 -> zero all operand and result registers, result_valid=0, -> DONE; 7 -> err_code=3, -> DONE.
REQ-021 LOAD: arm_to_fpga_data_ready SHALL be 1 for the whole state; capture on the cycle valid&&ready, then -> DONE; any load SHALL clear result_valid.
REQ-022 START: core_start=1 for exactly one cycle, watchdog cleared, -> COMPUTE.
REQ-023 COMPUTE: busy=1; on core_done, capture core_result, result_valid=1, err_code=0, -> DONE; watchdog reaching TIMEOUT_CYC-1 without core_done -> err_code=2, result unchanged, -> DONE.
REQ-024 If core_done and timeout coincide, core_done SHALL win; core_done outside COMPUTE SHALL be ignored.
REQ-025 WRITE: fpga_to_arm_data_valid=1 with result register on fpga_to_arm_data; leave on valid&&ready -> DONE; if result_valid=0, err_code=1 but transfer still completes.
REQ-026 DONE: fpga_to_arm_done=1 until fpga_to_arm_done_read sampled 1, then -> IDLE next cycle.
REQ-027 err_code SHALL be cleared on acceptance of every new legal command.
REQ-028 All handshake outputs and core_start SHALL be registered, no combinational input-to-output path.
REQ-029 fpga_to_arm_data SHALL hold result register value at all times, upper TX_SIZE-OP_WIDTH bits zero.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE and all outputs, operand, result and watchdog registers to 0, including mid-COMPUTE or mid-handshake.
REQ-031 After reset release, the first command SHALL be accepted on the first cycle cmd_valid=1.

Structure
REQ-032 Opcodes, state encoding and err_code values SHALL live in shared package rsa_pkg.
REQ-033 Operand registers and their load enables SHALL be one sub-module, rsa_operand_bank; FSM, watchdog and handshakes stay in rsa_cmd_ctrl.

Verification
REQ-034 LOAD_MOD with data {512'h5, 512'h7} -> core_modulus=7, core_rmodm=5, done asserted, status=0.
REQ-035 COMPUTE_EXP, core_done after 100 cycles with result 0xABCD -> exactly one core_start pulse, core_mode=0, then READ_RESULT returns 0xABCD, status result_valid=1.
REQ-036 COMPUTE_MONT with core_done never asserted, TIMEOUT_CYC=64 -> done after 64 cycles of COMPUTE, err_code=2, result_valid unchanged.
REQ-037 READ_RESULT directly after reset -> data 0 transferred, err_code=1; fpga_to_arm_data_ready held low 10 cycles keeps valid high, no state change.
REQ-038 reset pulsed mid-COMPUTE -> all outputs 0 same cycle, subsequent LOAD_EXP accepted normally.
REQ-039 Opcode 7, then cmd_valid pulsed during DONE -> err_code=3, second command ignored, IDLE after done_read.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared opcode, FSM state and error-code definitions for the RSA command controller.
package rsa_pkg;

  typedef enum logic [2:0] {
    OP_LOAD_MOD     = 3'd0,
    OP_LOAD_RSQ     = 3'd1,
    OP_LOAD_EXP     = 3'd2,
    OP_COMPUTE_EXP  = 3'd3,
    OP_COMPUTE_MONT = 3'd4,
    OP_READ_RESULT  = 3'd5,
    OP_CLEAR        = 3'd6,
    OP_ILLEGAL      = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_NO_RESULT = 2'd1,
    ERR_TIMEOUT   = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } err_e;

  function automatic logic is_load_op(input opcode_e op);
    return (op == OP_LOAD_MOD) || (op == OP_LOAD_RSQ) || (op == OP_LOAD_EXP);
  endfunction

endpackage

// File: rtl/rsa_operand_bank.sv
// Operand registers feeding the exponentiation core, written from one inbound data beat.
module rsa_operand_bank
  import rsa_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  opcode_e               i_load_op,
  input  logic [2*OP_WIDTH-1:0] i_data,
  output logic [OP_WIDTH-1:0]   o_modulus,
  output logic [OP_WIDTH-1:0]   o_rmodm,
  output logic [OP_WIDTH-1:0]   o_rsqmodm,
  output logic [OP_WIDTH-1:0]   o_exponent,
  output logic [OP_WIDTH-1:0]   o_x
);

  logic [OP_WIDTH-1:0] w_lo;
  logic [OP_WIDTH-1:0] w_hi;
  logic                w_ld_mod;
  logic                w_ld_rsq;
  logic                w_ld_exp;

  logic [OP_WIDTH-1:0] r_modulus;
  logic [OP_WIDTH-1:0] r_rmodm;
  logic [OP_WIDTH-1:0] r_rsqmodm;
  logic [OP_WIDTH-1:0] r_exponent;
  logic [OP_WIDTH-1:0] r_x;

  assign w_lo     = i_data[OP_WIDTH-1:0];
  assign w_hi     = i_data[2*OP_WIDTH-1:OP_WIDTH];
  assign w_ld_mod = i_load && (i_load_op == OP_LOAD_MOD);
  assign w_ld_rsq = i_load && (i_load_op == OP_LOAD_RSQ);
  assign w_ld_exp = i_load && (i_load_op == OP_LOAD_EXP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_modulus  <= '0;
      r_rmodm    <= '0;
      r_rsqmodm  <= '0;
      r_exponent <= '0;
      r_x        <= '0;
    end else if (i_clear) begin
      r_modulus  <= '0;
      r_rmodm    <= '0;
      r_rsqmodm  <= '0;
      r_exponent <= '0;
      r_x        <= '0;
    end else begin
      if (w_ld_mod) begin
        r_modulus <= w_lo;
        r_rmodm   <= w_hi;
      end
      if (w_ld_rsq) begin
        r_rsqmodm <= w_lo;
        r_x       <= w_hi;
      end
      // The high half of a LOAD_EXP beat carries nothing.
      if (w_ld_exp) begin
        r_exponent <= w_lo;
      end
    end
  end

  assign o_modulus  = r_modulus;
  assign o_rmodm    = r_rmodm;
  assign o_rsqmodm  = r_rsqmodm;
  assign o_exponent = r_exponent;
  assign o_x        = r_x;

endmodule

// File: rtl/rsa_cmd_ctrl.sv
// ARM-facing command controller for the RSA exponentiation core: command FSM,
// inbound/outbound data handshakes, core start/watchdog and result register.
module rsa_cmd_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned TX_SIZE     = 1024,
  parameter int unsigned OP_WIDTH    = 512,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         arm_to_fpga_cmd,
  input  logic                arm_to_fpga_cmd_valid,
  output logic                fpga_to_arm_done,
  input  logic                fpga_to_arm_done_read,
  input  logic                arm_to_fpga_data_valid,
  output logic                arm_to_fpga_data_ready,
  input  logic [TX_SIZE-1:0]  arm_to_fpga_data,
  output logic                fpga_to_arm_data_valid,
  input  logic                fpga_to_arm_data_ready,
  output logic [TX_SIZE-1:0]  fpga_to_arm_data,
  output logic                core_start,
  output logic                core_mode,
  output logic [OP_WIDTH-1:0] core_modulus,
  output logic [OP_WIDTH-1:0] core_rmodm,
  output logic [OP_WIDTH-1:0] core_rsqmodm,
  output logic [OP_WIDTH-1:0] core_exponent,
  output logic [OP_WIDTH-1:0] core_x,
  input  logic                core_done,
  input  logic [OP_WIDTH-1:0] core_result,
  output logic [3:0]          status
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  opcode_e             w_op;
  logic                w_unused_cmd;
  logic                w_load_fire;
  logic                w_clear;

  state_e              r_state;
  opcode_e             r_load_op;
  logic                r_core_start;
  logic                r_core_mode;
  logic                r_data_ready;
  logic                r_out_valid;
  logic                r_done;
  logic                r_busy;
  err_e                r_err;
  logic                r_result_valid;
  logic [OP_WIDTH-1:0] r_result;
  logic [WD_W-1:0]     r_wdog;

  assign w_op         = opcode_e'(arm_to_fpga_cmd[2:0]);
  assign w_unused_cmd = ^arm_to_fpga_cmd[31:3];

  assign w_load_fire = (r_state == ST_LOAD) && r_data_ready && arm_to_fpga_data_valid;
  assign w_clear     = (r_state == ST_IDLE) && arm_to_fpga_cmd_valid && (w_op == OP_CLEAR);

  rsa_operand_bank #(
    .OP_WIDTH (OP_WIDTH)
  ) u_bank (
    .clk        (clk),
    .rst        (reset),
    .i_clear    (w_clear),
    .i_load     (w_load_fire),
    .i_load_op  (r_load_op),
    .i_data     (arm_to_fpga_data[2*OP_WIDTH-1:0]),
    .o_modulus  (core_modulus),
    .o_rmodm    (core_rmodm),
    .o_rsqmodm  (core_rsqmodm),
    .o_exponent (core_exponent),
    .o_x        (core_x)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_load_op      <= OP_LOAD_MOD;
      r_core_start   <= 1'b0;
      r_core_mode    <= 1'b0;
      r_data_ready   <= 1'b0;
      r_out_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= ERR_NONE;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_wdog         <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (arm_to_fpga_cmd_valid) begin
            case (w_op)
              OP_LOAD_MOD, OP_LOAD_RSQ, OP_LOAD_EXP: begin
                r_err        <= ERR_NONE;
                r_load_op    <= w_op;
                r_data_ready <= 1'b1;
                r_state      <= ST_LOAD;
              end
              OP_COMPUTE_EXP, OP_COMPUTE_MONT: begin
                r_err        <= ERR_NONE;
                r_core_mode  <= (w_op == OP_COMPUTE_MONT);
                r_core_start <= 1'b1;
                r_state      <= ST_START;
              end
              OP_READ_RESULT: begin
                r_err       <= r_result_valid ? ERR_NONE : ERR_NO_RESULT;
                r_out_valid <= 1'b1;
                r_state     <= ST_WRITE;
              end
              OP_CLEAR: begin
                r_err          <= ERR_NONE;
                r_result       <= '0;
                r_result_valid <= 1'b0;
                r_done         <= 1'b1;
                r_state        <= ST_DONE;
              end
              default: begin
                r_err   <= ERR_ILLEGAL;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            endcase
          end
        end

        ST_LOAD: begin
          if (w_load_fire) begin
            r_data_ready   <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b1;
            r_state        <= ST_DONE;
          end
        end

        ST_START: begin
          r_core_start <= 1'b0;
          r_wdog       <= '0;
          r_busy       <= 1'b1;
          r_state      <= ST_COMPUTE;
        end

        // core_done is checked first so it wins over a coincident timeout.
        ST_COMPUTE: begin
          if (core_done) begin
            r_result       <= core_result;
            r_result_valid <= 1'b1;
            r_err          <= ERR_NONE;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
            r_state        <= ST_DONE;
          end else if (r_wdog == WD_LAST) begin
            r_err   <= ERR_TIMEOUT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        ST_WRITE: begin
          if (fpga_to_arm_data_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (fpga_to_arm_done_read) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fpga_to_arm_done       = r_done;
  assign arm_to_fpga_data_ready = r_data_ready;
  assign fpga_to_arm_data_valid = r_out_valid;
  assign fpga_to_arm_data       = TX_SIZE'(r_result);
  assign core_start             = r_core_start;
  assign core_mode              = r_core_mode;
  assign status                 = {r_err, r_result_valid, r_busy};

endmodule
